mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-port memory arbiter that shares one SRAM-style memory interface between instruction fetch (IFU) and load/store (LSU).
- Sits between the fetch/LSU stages of the multi-cycle core and the memory model/DPI bridge.
- Allows one outstanding transaction at a time, round-robin on conflict, with a response watchdog and error flag.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; write mask width is DATA_W/8.
- TIMEOUT_CYCLES, 255, maximum number of WAIT cycles before a forced error response; must be ≥1.
- ERR_DATA, 32'hDEADBEEF, rdata returned on a timeout response.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- ifu_req_valid  in  1  fetch request.
- ifu_req_ready  out  1  fetch request accepted this cycle.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_rsp_valid  out  1  fetch response pulse.
- ifu_rdata  out  DATA_W  fetched word.
- lsu_req_valid  in  1  load/store request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wen  in  1  1 = store.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  DATA_W/8  byte enables.
- lsu_rsp_valid  out  1  LSU response pulse (load data or store ack).
- lsu_rdata  out  DATA_W  load data.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  as LSU  latched request fields.
- mem_rsp_valid  in  1  memory response/ack.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  FSM not in IDLE.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (rst=0, async): state=IDLE; all req_ready, rsp_valid, mem_req_valid, err, busy = 0; all data/addr outputs = 0; last_grant=IFU, so LSU wins the first conflict. Any in-flight transaction is dropped with no response.
- States: IDLE, REQ, WAIT.
- IDLE: grant the winner among the valid requesters.
  - One requester valid → that requester wins.
  - Both valid → the one not granted last wins.
  - Winner's req_ready=1 combinationally in the same cycle; the loser's req_ready=0.
  - On grant: latch owner, addr, wen/wdata/wmask (IFU: wen=0, wmask=0, wdata=0); update last_grant; go to REQ.
  - No valid request → stay in IDLE.
- REQ: mem_req_valid=1 with the latched fields, held stable until mem_req_ready=1, then go to WAIT and clear the timeout counter. req_ready=0 to both requesters.
- WAIT: mem_req_valid=0; counter increments each cycle.
  - mem_rsp_valid=1 → owner's rsp_valid=1 for exactly that cycle, owner rdata=mem_rdata (combinational pass-through); go to IDLE.
  - Counter reaches TIMEOUT_CYCLES with no response → owner rsp_valid=1, rdata=ERR_DATA, err←1; go to IDLE.
  - A response and timeout in the same cycle count as a response; err is unchanged.
- mem_rsp_valid is ignored in IDLE and REQ.
- The non-owner's rsp_valid is always 0; rdata outputs are 0 when their rsp_valid=0.
- Stores complete on mem_rsp_valid (ack); lsu_rdata on a store response is mem_rdata, and its value is don't-care.
- Latency: accept at cycle N; mem_req_valid at N+1. With mem_req_ready at N+1 and mem_rsp_valid at N+2, the response is at N+2. Minimum 2 cycles accept→response; the next grant is possible at N+3.
- A requester may drop valid while not ready; only the accept cycle's fields are used.
- busy=1 in REQ and WAIT.

Decomposition:
- Shared package mem_pkg:
  - state enum (IDLE/REQ/WAIT)
  - owner enum (OWN_IFU/OWN_LSU)
  - ERR_DATA default
  - mask-width localparam
- One sub-module, rr_arb2: 2-way round-robin grant, combinational from (req[1:0], last_grant), with last_grant held in a flop inside the arbiter and updated on accept.

Test Plan:
- IFU only: ifu addr 0x80000000 accepted cycle 0; mem_req_ready=1 at cycle 1; mem_rsp_valid with rdata 0x00100093 at cycle 2 → ifu_rsp_valid=1, ifu_rdata=0x00100093 at cycle 2; lsu_rsp_valid stays 0.
- Conflict: both valid continuously, LSU store to 0x80001000 with wdata 0x12345678, wmask 4'b1111 → LSU is granted first (mem_wen=1, fields match), then IFU, then LSU, alternating on each transaction.
- Backpressure: mem_req_ready held 0 for 5 cycles → mem_req_valid=1 and mem_addr/mem_wdata stable for all 5 cycles; both req_ready=0; a response occurs only after the handshake.
- Timeout with TIMEOUT_CYCLES=4: no mem_rsp_valid → owner rsp_valid after 4 WAIT cycles with rdata=0xDEADBEEF; err=1 and stays 1 through later normal transactions.
- Async reset in WAIT: rst=0 mid-cycle → state IDLE immediately; mem_req_valid, busy, err = 0; no rsp_valid; a late mem_rsp_valid after release is ignored.
- Spurious response: mem_rsp_valid=1 in IDLE → no rsp_valid on either side and no state change.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the IFU/LSU single-port memory arbiter.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
    localparam int BYTE_W     = 8;
    localparam int MASK_W_DEF = 32 / BYTE_W;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant; bit 0 = IFU, bit 1 = LSU. Remembers the last winner.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    owner_e last_grant;

    always_comb begin
        gnt = req;
        // On conflict the side that did not win last time gets the grant.
        if (req == 2'b11) begin
            gnt = (last_grant == OWN_IFU) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= OWN_IFU;
        end else if (accept) begin
            last_grant <= gnt[1] ? OWN_LSU : OWN_IFU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one SRAM-style memory port between fetch and load/store, one transaction
// in flight, with a response watchdog that returns ERR_DATA and sets a sticky err.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int              ADDR_W         = 32,
    parameter int              DATA_W         = 32,
    parameter int              TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] ERR_DATA     = ERR_DATA_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ifu_req_valid,
    output logic                 ifu_req_ready,
    input  logic [ADDR_W-1:0]    ifu_addr,
    output logic                 ifu_rsp_valid,
    output logic [DATA_W-1:0]    ifu_rdata,
    input  logic                 lsu_req_valid,
    output logic                 lsu_req_ready,
    input  logic [ADDR_W-1:0]    lsu_addr,
    input  logic                 lsu_wen,
    input  logic [DATA_W-1:0]    lsu_wdata,
    input  logic [DATA_W/8-1:0]  lsu_wmask,
    output logic                 lsu_rsp_valid,
    output logic [DATA_W-1:0]    lsu_rdata,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_wen,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic [DATA_W/8-1:0]  mem_wmask,
    input  logic                 mem_rsp_valid,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 busy,
    output logic                 err,
    output state_e               dbg_state
);

    localparam int MASK_W = DATA_W / BYTE_W;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_e           state;
    owner_e           owner;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       gnt;
    logic             accept;
    logic             timeout;
    logic             rsp_fire;
    logic [DATA_W-1:0] rsp_data;

    // Grants only exist in IDLE and never while reset is asserted.
    assign accept = (state == IDLE) && rst && (ifu_req_valid || lsu_req_valid);

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({lsu_req_valid, ifu_req_valid}),
        .accept (accept),
        .gnt    (gnt)
    );

    assign ifu_req_ready = accept && gnt[0];
    assign lsu_req_ready = accept && gnt[1];

    assign timeout  = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_fire = (state == WAIT) && (mem_rsp_valid || timeout);
    assign rsp_data = mem_rsp_valid ? mem_rdata : ERR_DATA;

    assign ifu_rsp_valid = rsp_fire && (owner == OWN_IFU);
    assign lsu_rsp_valid = rsp_fire && (owner == OWN_LSU);
    assign ifu_rdata     = ifu_rsp_valid ? rsp_data : '0;
    assign lsu_rdata     = lsu_rsp_valid ? rsp_data : '0;

    assign mem_req_valid = (state == REQ);
    assign busy          = (state != IDLE);
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_IFU;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            wait_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= REQ;
                        if (gnt[1]) begin
                            owner     <= OWN_LSU;
                            mem_addr  <= lsu_addr;
                            mem_wen   <= lsu_wen;
                            mem_wdata <= lsu_wdata;
                            mem_wmask <= lsu_wmask;
                        end else begin
                            owner     <= OWN_IFU;
                            mem_addr  <= ifu_addr;
                            mem_wen   <= 1'b0;
                            mem_wdata <= '0;
                            mem_wmask <= MASK_W'(0);
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    // A response arriving on the timeout cycle wins and leaves err alone.
                    if (mem_rsp_valid) begin
                        state <= IDLE;
                    end else if (timeout) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle watchdog; expected values are hand-computed.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [3:0]    lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_wmask;
    logic          busy, err;
    state_e        dbg_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; inputs change there and outputs are sampled 1ns later.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic exp_lsu;
        rst = 1'b0;
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;

        // Reset state
        step(); #1;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_mreq", mem_req_valid, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_state", dbg_state, IDLE);
        step(); rst = 1'b1;

        // IFU only
        step(); ifu_req_valid = 1; ifu_addr = 32'h8000_0000; #1;
        chk("ifu_ready", ifu_req_ready, 1);
        chk("ifu_lsu_ready", lsu_req_ready, 0);
        step(); ifu_req_valid = 0; mem_req_ready = 1; #1;
        chk("ifu_mreq", mem_req_valid, 1);
        chk("ifu_maddr", mem_addr, 32'h8000_0000);
        chk("ifu_mwen", mem_wen, 0);
        chk("ifu_mwmask", mem_wmask, 0);
        chk("ifu_busy", busy, 1);
        step(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0010_0093; #1;
        chk("ifu_rsp", ifu_rsp_valid, 1);
        chk("ifu_rdata", ifu_rdata, 32'h0010_0093);
        chk("ifu_lsu_rsp", lsu_rsp_valid, 0);
        chk("ifu_lsu_rdata", lsu_rdata, 0);
        step(); mem_rsp_valid = 0; #1;
        chk("ifu_idle", busy, 0);
        chk("ifu_rsp_clr", ifu_rsp_valid, 0);
        chk("ifu_rdata_clr", ifu_rdata, 0);

        // Conflict: both valid continuously, LSU wins first, then alternate
        for (int i = 0; i < 4; i++) begin
            exp_lsu = (i % 2 == 0);
            step();
            mem_rsp_valid = 0;
            ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
            lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
            lsu_wdata = 32'h1234_5678; lsu_wmask = 4'b1111;
            #1;
            chk("cf_lsu_ready", lsu_req_ready, exp_lsu);
            chk("cf_ifu_ready", ifu_req_ready, !exp_lsu);
            step(); mem_req_ready = 1; #1;
            chk("cf_mwen", mem_wen, exp_lsu);
            chk("cf_maddr", mem_addr, exp_lsu ? 32'h8000_1000 : 32'h8000_0004);
            chk("cf_mwdata", mem_wdata, exp_lsu ? 32'h1234_5678 : 32'h0);
            chk("cf_mwmask", mem_wmask, exp_lsu ? 4'hF : 4'h0);
            chk("cf_no_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
            step(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'hA000_0000 + i; #1;
            chk("cf_lsu_rsp", lsu_rsp_valid, exp_lsu);
            chk("cf_ifu_rsp", ifu_rsp_valid, !exp_lsu);
            chk("cf_rdata", exp_lsu ? lsu_rdata : ifu_rdata, 32'hA000_0000 + i);
        end
        step(); mem_rsp_valid = 0; ifu_req_valid = 0; lsu_req_valid = 0;

        // Backpressure on a load; spurious mem_rsp_valid during REQ is ignored
        step(); lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_2000;
        lsu_wdata = 32'hAAAA_5555; lsu_wmask = 4'b0011; #1;
        chk("bp_accept", lsu_req_ready, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            lsu_req_valid = 0; ifu_req_valid = 1; lsu_addr = 32'h1111_0000 + i;
            lsu_wdata = '1; mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h7777_7777;
            #1;
            chk("bp_mreq", mem_req_valid, 1);
            chk("bp_maddr", mem_addr, 32'h8000_2000);
            chk("bp_mwdata", mem_wdata, 32'hAAAA_5555);
            chk("bp_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
            chk("bp_no_rsp", lsu_rsp_valid, 0);
        end
        step(); mem_rsp_valid = 0; ifu_req_valid = 0; mem_req_ready = 1; #1;
        chk("bp_hs_mreq", mem_req_valid, 1);
        chk("bp_mwmask", mem_wmask, 4'b0011);
        step(); mem_req_ready = 0; #1;
        chk("bp_wait_mreq", mem_req_valid, 0);
        chk("bp_wait_state", dbg_state, WAIT);
        chk("bp_wait_norsp", lsu_rsp_valid, 0);
        step(); mem_rsp_valid = 1; mem_rdata = 32'h0BAD_F00D; #1;
        chk("bp_rsp", lsu_rsp_valid, 1);
        chk("bp_rdata", lsu_rdata, 32'h0BAD_F00D);
        step(); mem_rsp_valid = 0; #1;
        chk("bp_idle", busy, 0);

        // Watchdog: no response, forced error on the 4th WAIT cycle
        step(); ifu_req_valid = 1; ifu_addr = 32'h8000_3000; #1;
        chk("to_accept", ifu_req_ready, 1);
        step(); ifu_req_valid = 0; mem_req_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step(); mem_req_ready = 0; #1;
            chk("to_wait_norsp", ifu_rsp_valid, 0);
            chk("to_wait_err", err, 0);
        end
        step(); #1;
        chk("to_rsp", ifu_rsp_valid, 1);
        chk("to_rdata", ifu_rdata, 32'hDEAD_BEEF);
        chk("to_lsu_rsp", lsu_rsp_valid, 0);
        step(); #1;
        chk("to_err_set", err, 1);
        chk("to_idle", busy, 0);

        // err stays set across a normal transaction
        step(); lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_4000; #1;
        chk("st_accept", lsu_req_ready, 1);
        step(); lsu_req_valid = 0; mem_req_ready = 1;
        step(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0; #1;
        chk("st_ack", lsu_rsp_valid, 1);
        step(); mem_rsp_valid = 0; #1;
        chk("st_err_sticky", err, 1);

        // Async reset while in WAIT
        step(); lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_5000;
        step(); lsu_req_valid = 0; mem_req_ready = 1;
        step(); mem_req_ready = 0; #1;
        chk("ar_pre_state", dbg_state, WAIT);
        #1 rst = 1'b0;
        #1;
        chk("ar_state", dbg_state, IDLE);
        chk("ar_busy", busy, 0);
        chk("ar_err", err, 0);
        chk("ar_mreq", mem_req_valid, 0);
        chk("ar_maddr", mem_addr, 0);
        chk("ar_rsp", lsu_rsp_valid, 0);
        step(); rst = 1'b1;

        // Late / spurious response in IDLE
        step(); mem_rsp_valid = 1; mem_rdata = 32'h5A5A_5A5A; #1;
        chk("sp_lsu_rsp", lsu_rsp_valid, 0);
        chk("sp_ifu_rsp", ifu_rsp_valid, 0);
        step(); mem_rsp_valid = 0; #1;
        chk("sp_state", dbg_state, IDLE);

        // After reset the LSU wins a conflict; response on the timeout cycle counts as normal
        step(); ifu_req_valid = 1; lsu_req_valid = 1; lsu_addr = 32'h8000_6000; #1;
        chk("rr_lsu_first", lsu_req_ready, 1);
        chk("rr_ifu_lose", ifu_req_ready, 0);
        step(); ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step(); mem_req_ready = 0;
        end
        step(); mem_rsp_valid = 1; mem_rdata = 32'h55AA_55AA; #1;
        chk("tr_rsp", lsu_rsp_valid, 1);
        chk("tr_rdata", lsu_rdata, 32'h55AA_55AA);
        step(); mem_rsp_valid = 0; #1;
        chk("tr_err", err, 0);
        chk("tr_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
